// File: rtl/vram_wr_queue.sv
// ---------------------------------------------------------------------------
// vram_wr_queue
//
// CPU-side write queue feeding the video block's VRAM write port. CPU memory
// writes aimed at video memory are filtered and stored in a small show-ahead
// FIFO. The video fetch engine sees the head entry on vaddr_o/md_o/wr_o/
// double_cas_o. It retires that entry by pulsing wr_ack_i in its WR_CPU slot.
// Between slots the queue absorbs CPU bursts. When the queue is full it asks
// the CPU to wait.
//
// Ports:
//   clk42_i       system clock (42 MHz)
//   res_n_i       synchronous active-low reset
//   cpu_wr_i      one-cycle CPU write strobe
//   cpu_addr_i    write address; bit19=1 graphic space, bit19=0 Spectrum space
//   cpu_dat_i     write data
//   cpu_word_i    16-bit (double CAS) write
//   scr_wr_off_i  block writes into the Spectrum screen window
//   wr_ack_i      video engine consumed the head entry (one-cycle pulse)
//   vaddr_o       head entry address
//   md_o          head entry data
//   wr_o          head entry valid (queue non-empty)
//   double_cas_o  head entry word flag
//   cpu_wait_o    queue full, CPU must hold off
//   ovf_o         sticky: a write was dropped while the queue was full
//   level_o       current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module vram_wr_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [13:0] SCR_LIMIT = 14'h1B00
) (
   input  logic                     clk42_i,
   input  logic                     res_n_i,
   input  logic                     cpu_wr_i,
   input  logic [19:0]              cpu_addr_i,
   input  logic [15:0]              cpu_dat_i,
   input  logic                     cpu_word_i,
   input  logic                     scr_wr_off_i,
   input  logic                     wr_ack_i,
   output logic [19:0]              vaddr_o,
   output logic [15:0]              md_o,
   output logic                     wr_o,
   output logic                     double_cas_o,
   output logic                     cpu_wait_o,
   output logic                     ovf_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] TWO_COUNT  = CW'(2);

   // Entry storage. No reset is needed: only slots between the head and tail
   // pointers are ever read as valid data.
   logic [19:0]   addrMem [DEPTH];
   logic [15:0]   datMem  [DEPTH];
   logic          wordMem [DEPTH];

   logic [PW-1:0] headPtr_q, headPtr_d;
   logic [PW-1:0] tailPtr_q, tailPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic [19:0]   vaddr_q, vaddr_d;
   logic [15:0]   md_q, md_d;
   logic          wr_q;
   logic          doubleCas_q, doubleCas_d;
   logic          cpuWait_q;
   logic          ovf_q;

   logic          accept;
   logic          tailMatch;
   logic          isFull;
   logic          doPop;
   logic          doMerge;
   logic          doPush;
   logic          doDrop;
   logic          writeEn;
   logic [PW-1:0] lastIdx;
   logic [PW-1:0] writeIdx;

   // Decide what happens this cycle. A write is accepted if it targets
   // graphic space, or if it targets the Spectrum screen window and screen
   // writes are enabled. An accepted write that repeats the {addr,word} of
   // the tail entry overwrites only the tail data. This never applies to the
   // head entry, because the video engine may be fetching it. Otherwise the
   // write is pushed. When the queue is full, a push is still allowed if a pop
   // frees a slot in the same cycle. Without that pop the write is dropped and
   // flagged as an overflow.
   always_comb begin
      accept    = cpu_wr_i & (cpu_addr_i[19] |
                  (~scr_wr_off_i & (cpu_addr_i[13:0] < SCR_LIMIT)));
      lastIdx   = tailPtr_q - 1'b1;
      tailMatch = (addrMem[lastIdx] == cpu_addr_i) &&
                  (wordMem[lastIdx] == cpu_word_i);
      isFull    = (count_q == FULL_COUNT);
      doPop     = wr_ack_i && (count_q != '0);
      doMerge   = accept && (count_q >= TWO_COUNT) && tailMatch;
      doPush    = accept && !doMerge && (!isFull || doPop);
      doDrop    = accept && !doMerge && isFull && !doPop;
      writeEn   = doPush || doMerge;
      writeIdx  = doMerge ? lastIdx : tailPtr_q;
   end

   // Compute the next pointer and occupancy values. A push and a pop in the
   // same cycle leave the count unchanged.
   always_comb begin
      headPtr_d = doPop  ? headPtr_q + 1'b1 : headPtr_q;
      tailPtr_d = doPush ? tailPtr_q + 1'b1 : tailPtr_q;
      count_d   = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + 1'b1;
      end else if (doPop && !doPush) begin
         count_d = count_q - 1'b1;
      end
   end

   // Work out what the head entry will be next cycle, so the outputs can be
   // registered from it. If this cycle's write lands in the slot that becomes
   // the head, bypass the memory. This happens when:
   //   - a push goes into an empty queue,
   //   - a push coincides with a pop at count 1, or
   //   - a merge coincides with a pop at count 2.
   // When the queue goes empty, the previous head values are held. This keeps
   // the outputs at their reset value until the first push.
   always_comb begin
      vaddr_d     = vaddr_q;
      md_d        = md_q;
      doubleCas_d = doubleCas_q;
      if (count_d != '0) begin
         if (writeEn && (writeIdx == headPtr_d)) begin
            vaddr_d     = cpu_addr_i;
            md_d        = cpu_dat_i;
            doubleCas_d = cpu_word_i;
         end else begin
            vaddr_d     = addrMem[headPtr_d];
            md_d        = datMem[headPtr_d];
            doubleCas_d = wordMem[headPtr_d];
         end
      end
   end

   // Write entry storage on a push or merge. A merge only changes the data,
   // but rewriting the identical address and word flag is harmless.
   always_ff @(posedge clk42_i) begin
      if (res_n_i && writeEn) begin
         addrMem[writeIdx] <= cpu_addr_i;
         datMem[writeIdx]  <= cpu_dat_i;
         wordMem[writeIdx] <= cpu_word_i;
      end
   end

   // Register the control state and all outputs. Reset discards any queued
   // entries and clears the sticky overflow flag.
   always_ff @(posedge clk42_i) begin
      if (!res_n_i) begin
         headPtr_q   <= '0;
         tailPtr_q   <= '0;
         count_q     <= '0;
         vaddr_q     <= '0;
         md_q        <= '0;
         wr_q        <= 1'b0;
         doubleCas_q <= 1'b0;
         cpuWait_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         headPtr_q   <= headPtr_d;
         tailPtr_q   <= tailPtr_d;
         count_q     <= count_d;
         vaddr_q     <= vaddr_d;
         md_q        <= md_d;
         wr_q        <= (count_d != '0);
         doubleCas_q <= doubleCas_d;
         cpuWait_q   <= (count_d == FULL_COUNT);
         ovf_q       <= ovf_q | doDrop;
      end
   end

   assign vaddr_o      = vaddr_q;
   assign md_o         = md_q;
   assign wr_o         = wr_q;
   assign double_cas_o = doubleCas_q;
   assign cpu_wait_o   = cpuWait_q;
   assign ovf_o        = ovf_q;
   assign level_o      = count_q;

endmodule

// File: tb/tb_vram_wr_queue.sv
// ---------------------------------------------------------------------------
// tb_vram_wr_queue
//
// Directed testbench for vram_wr_queue with DEPTH=4. It covers:
//   - reset state,
//   - the address filter,
//   - fill, overflow and drain order,
//   - a push and pop in the same cycle,
//   - write combining, and
//   - reset while entries are queued.
// Expected values are worked out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_vram_wr_queue;

   logic        clock;
   logic        resN;
   logic        cpuWr;
   logic [19:0] cpuAddr;
   logic [15:0] cpuDat;
   logic        cpuWord;
   logic        scrWrOff;
   logic        wrAck;
   logic [19:0] vaddr;
   logic [15:0] md;
   logic        wr;
   logic        doubleCas;
   logic        cpuWait;
   logic        ovf;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   vram_wr_queue #(
      .DEPTH     (4),
      .SCR_LIMIT (14'h1B00)
   ) dut (
      .clk42_i      (clock),
      .res_n_i      (resN),
      .cpu_wr_i     (cpuWr),
      .cpu_addr_i   (cpuAddr),
      .cpu_dat_i    (cpuDat),
      .cpu_word_i   (cpuWord),
      .scr_wr_off_i (scrWrOff),
      .wr_ack_i     (wrAck),
      .vaddr_o      (vaddr),
      .md_o         (md),
      .wr_o         (wr),
      .double_cas_o (doubleCas),
      .cpu_wait_o   (cpuWait),
      .ovf_o        (ovf),
      .level_o      (level)
   );

   // 42 MHz-ish free-running clock.
   initial clock = 1'b0;
   always #12 clock = ~clock;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs from the falling edge. Outputs are then
   // available for checking 1 ns after the following rising edge.
   task automatic applyStimulus(input logic wrIn, input logic [19:0] addrIn,
                                input logic [15:0] datIn, input logic wordIn,
                                input logic ackIn);
      @(negedge clock);
      cpuWr   = wrIn;
      cpuAddr = addrIn;
      cpuDat  = datIn;
      cpuWord = wordIn;
      wrAck   = ackIn;
      @(posedge clock);
      #1;
      cpuWr = 1'b0;
      wrAck = 1'b0;
   endtask

   // Hold reset low for one clock edge, then release it.
   task automatic pulseReset();
      @(negedge clock);
      resN = 1'b0;
      @(posedge clock);
      #1;
      resN = 1'b1;
   endtask

   // Run the directed vectors in order.
   initial begin
      resN     = 1'b0;
      cpuWr    = 1'b0;
      cpuAddr  = '0;
      cpuDat   = '0;
      cpuWord  = 1'b0;
      scrWrOff = 1'b0;
      wrAck    = 1'b0;
      pulseReset();

      checkOutput("rst_wr",    32'(wr),        32'h0);
      checkOutput("rst_level", 32'(level),     32'h0);
      checkOutput("rst_wait",  32'(cpuWait),   32'h0);
      checkOutput("rst_ovf",   32'(ovf),       32'h0);
      checkOutput("rst_vaddr", 32'(vaddr),     32'h0);
      checkOutput("rst_md",    32'(md),        32'h0);
      checkOutput("rst_dcas",  32'(doubleCas), 32'h0);

      // Single word write, then retire it.
      applyStimulus(1'b1, 20'h80123, 16'hBEEF, 1'b1, 1'b0);
      checkOutput("single_wr",    32'(wr),        32'h1);
      checkOutput("single_vaddr", 32'(vaddr),     32'h80123);
      checkOutput("single_md",    32'(md),        32'hBEEF);
      checkOutput("single_dcas",  32'(doubleCas), 32'h1);
      checkOutput("single_level", 32'(level),     32'h1);
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("single_ack_wr",    32'(wr),    32'h0);
      checkOutput("single_ack_level", 32'(level), 32'h0);

      // An ack on an empty queue is ignored.
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("empty_ack_level", 32'(level), 32'h0);

      // Address filter.
      scrWrOff = 1'b0;
      applyStimulus(1'b1, 20'h01AFF, 16'h1111, 1'b0, 1'b0);
      checkOutput("filt_last_in", 32'(level), 32'h1);
      applyStimulus(1'b1, 20'h01B00, 16'h2222, 1'b0, 1'b0);
      checkOutput("filt_limit", 32'(level), 32'h1);
      scrWrOff = 1'b1;
      applyStimulus(1'b1, 20'h00010, 16'h3333, 1'b0, 1'b0);
      checkOutput("filt_scroff", 32'(level), 32'h1);
      applyStimulus(1'b1, 20'h80010, 16'h4444, 1'b0, 1'b0);
      checkOutput("filt_gfx",   32'(level), 32'h2);
      checkOutput("filt_head",  32'(vaddr), 32'h01AFF);
      scrWrOff = 1'b0;
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("filt_pop1_vaddr", 32'(vaddr), 32'h80010);
      checkOutput("filt_pop1_md",    32'(md),    32'h4444);
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("filt_pop2_level", 32'(level), 32'h0);

      // Fill to full, then overflow.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 20'h80100 + 20'(i), 16'(i + 1), 1'b0, 1'b0);
         if (i == 2) checkOutput("fill3_wait", 32'(cpuWait), 32'h0);
      end
      checkOutput("fill_wait",  32'(cpuWait), 32'h1);
      checkOutput("fill_level", 32'(level),   32'h4);
      applyStimulus(1'b1, 20'h80104, 16'h0005, 1'b0, 1'b0);
      checkOutput("ovf_flag",  32'(ovf),   32'h1);
      checkOutput("ovf_level", 32'(level), 32'h4);
      checkOutput("ovf_vaddr", 32'(vaddr), 32'h80100);
      checkOutput("ovf_md",    32'(md),    32'h0001);
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b0);
      checkOutput("ovf_sticky", 32'(ovf), 32'h1);

      // Full queue with a push and a pop in the same cycle.
      pulseReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 20'h80100 + 20'(i), 16'(i + 1), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 20'h80105, 16'h0005, 1'b0, 1'b1);
      checkOutput("pp_level", 32'(level),   32'h4);
      checkOutput("pp_ovf",   32'(ovf),     32'h0);
      checkOutput("pp_wait",  32'(cpuWait), 32'h1);
      checkOutput("pp_head",  32'(md),      32'h0002);
      for (int i = 3; i <= 5; i++) begin
         applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
         checkOutput("pp_drain_md", 32'(md), 32'(i));
         if (i == 3) checkOutput("pp_wait_drop", 32'(cpuWait), 32'h0);
      end
      checkOutput("pp_last_vaddr", 32'(vaddr), 32'h80105);
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("pp_empty_wr", 32'(wr), 32'h0);

      // Write combining.
      applyStimulus(1'b1, 20'h80000, 16'h0001, 1'b0, 1'b0);
      applyStimulus(1'b1, 20'h80002, 16'h0002, 1'b0, 1'b0);
      applyStimulus(1'b1, 20'h80002, 16'h00FF, 1'b0, 1'b0);
      checkOutput("comb_level", 32'(level), 32'h2);
      checkOutput("comb_head",  32'(md),    32'h0001);
      applyStimulus(1'b0, 20'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("comb_merged", 32'(md),    32'h00FF);
      checkOutput("comb_lvl1",   32'(level), 32'h1);
      applyStimulus(1'b1, 20'h80002, 16'h0123, 1'b0, 1'b0);
      checkOutput("comb_nohead_level", 32'(level), 32'h2);
      checkOutput("comb_nohead_md",    32'(md),    32'h00FF);

      // Reset with three entries queued.
      applyStimulus(1'b1, 20'h80300, 16'h0300, 1'b0, 1'b0);
      checkOutput("mid_level", 32'(level), 32'h3);
      pulseReset();
      checkOutput("mid_rst_wr",    32'(wr),      32'h0);
      checkOutput("mid_rst_level", 32'(level),   32'h0);
      checkOutput("mid_rst_ovf",   32'(ovf),     32'h0);
      checkOutput("mid_rst_wait",  32'(cpuWait), 32'h0);
      applyStimulus(1'b1, 20'h80400, 16'hABCD, 1'b1, 1'b0);
      checkOutput("post_wr",    32'(wr),        32'h1);
      checkOutput("post_vaddr", 32'(vaddr),     32'h80400);
      checkOutput("post_md",    32'(md),        32'hABCD);
      checkOutput("post_dcas",  32'(doubleCas), 32'h1);
      checkOutput("post_level", 32'(level),     32'h1);

      // Push and pop together at count 1: the new entry becomes head.
      applyStimulus(1'b1, 20'h80500, 16'h5555, 1'b0, 1'b1);
      checkOutput("c1_level", 32'(level),     32'h1);
      checkOutput("c1_vaddr", 32'(vaddr),     32'h80500);
      checkOutput("c1_md",    32'(md),        32'h5555);
      checkOutput("c1_dcas",  32'(doubleCas), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_wr_queue.md
Name: vram_wr_queue

Overview:
- CPU-side producer for the video block's VRAM write port; drives vaddr/md/wr/double_cas toward the video fetch engine.
- Captures CPU memory writes that target video memory, filters Spectrum-mode writes against the screen window, and buffers them in a small FIFO.
- The video engine retires one entry per WR_CPU slot by pulsing wr_ack_i; the queue absorbs CPU bursts between slots and requests CPU wait when full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SCR_LIMIT, 14'h1B00, exclusive upper bound on Spectrum-mode offset addr[13:0]; covers pixels plus attributes.

Ports:
- clk42_i  in  1  system clock, 42 MHz
- res_n_i  in  1  synchronous active-low reset
- cpu_wr_i  in  1  one-cycle CPU write strobe
- cpu_addr_i  in  20  write address; bit19=1 graphic space, bit19=0 Spectrum space
- cpu_dat_i  in  16  write data
- cpu_word_i  in  1  16-bit (double CAS) write
- scr_wr_off_i  in  1  direct-port bit2: block Spectrum-screen writes
- wr_ack_i  in  1  video engine consumed head entry; one-cycle pulse in WR_CPU slot
- vaddr_o  out  20  head address
- md_o  out  16  head data
- wr_o  out  1  head valid (queue non-empty)
- double_cas_o  out  1  head word flag
- cpu_wait_o  out  1  queue full; CPU must hold off
- ovf_o  out  1  sticky: a write was dropped while full
- level_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset when res_n_i=0 at a clk42_i edge: count=0, pointers=0, wr_o=0, cpu_wait_o=0, ovf_o=0, level_o=0, vaddr_o/md_o/double_cas_o=0. Reset has priority over all events; in-flight entries are discarded.
- Accept filter, with acc = cpu_wr_i & (cpu_addr_i[19] | (~scr_wr_off_i & cpu_addr_i[13:0] < SCR_LIMIT)).
  - Non-accepted strobes are ignored: no state change, no ovf.
- Show-ahead FIFO; outputs are registered from the head entry.
  - Push in cycle N into an empty queue -> wr_o=1 with that entry on vaddr_o/md_o/double_cas_o at N+1.
- Pop: wr_ack_i=1 with count>0 advances head; next entry is visible the following cycle, or wr_o drops to 0 if count becomes 0.
  - wr_ack_i with count=0 is ignored.
- Write combining: if acc and count>=2 and {addr,word} equals the tail entry, overwrite tail data only; count unchanged.
  - Never merge into the head entry (count=1); push a new entry instead.
- Simultaneous acc and pop:
  - count unchanged (count-1+1).
  - When full, the push is accepted: the slot frees the same cycle.
  - When count=1, the new entry becomes head at N+1.
- Full (count=DEPTH), acc, no pop: entry dropped, ovf_o set to 1 and held until reset. Data at head is unchanged.
- cpu_wait_o = registered (next_count==DEPTH), so it is valid the cycle after the push that fills the queue. It deasserts the cycle after the pop.
- level_o = registered count, range 0..DEPTH. Pointers wrap modulo DEPTH.
- Only combinational outputs: none. All outputs are flops.

Test Plan:
- Reset, then a single write with addr=20'h80123, dat=16'hBEEF, word=1 -> next cycle wr_o=1, vaddr_o=20'h80123, md_o=16'hBEEF, double_cas_o=1, level_o=1. After wr_ack_i pulse -> wr_o=0, level_o=0.
- Filter: scr_wr_off_i=0, write addr=20'h01AFF -> queued. Write addr=20'h01B00 -> ignored. scr_wr_off_i=1, addr=20'h00010 -> ignored. addr=20'h80010 -> queued. Final level_o=2.
- Fill DEPTH=4 with no acks -> cpu_wait_o=1 after 4th push. 5th write -> dropped, ovf_o=1, level_o=4. Head still holds the first entry.
- Full queue, wr_ack_i and cpu_wr_i in the same cycle -> level_o stays 4, no ovf_o. Drain order equals push order, including the new entry last.
- Combining: push A(addr 20'h80000, 16'h0001), then B(addr 20'h80002, 16'h0002), then B'(addr 20'h80002, 16'h00FF) -> level_o=2. Drain yields 0001 then 00FF. A repeat write to the head address with count=1 -> level_o=2.
- Assert reset mid-queue with level_o=3 -> next cycle wr_o=0, level_o=0, ovf_o=0, cpu_wait_o=0. A following write is presented normally.
